// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and BCD digit type for the stopwatch
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} sw_state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decimal digit counter with synchronous clear and carry out
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);
  assign carry = inc & (q == BCD_MAX);
  // digit register: clear wins, otherwise step 0..9 with rollover on carry
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= carry ? '0 : q + 4'd1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/lap/pause FSM, prescaler and lap latch over a two-digit BCD count
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  sw_state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  bcd_t tens, ones, lat_tens_q, lat_ones_q;
  logic active, tick, clr, lap_cap, ones_carry, wrap_next;
  logic running_q, lap_active_q, wrap_q;
  assign active  = state_q == RUN || state_q == LAP;
  assign tick    = active && pre_q == PW'(TICK_DIV - 1);
  assign clr     = state_q == PAUSE && clear;
  assign lap_cap = state_q == RUN && !start_stop && lap;
  // next state: only commands legal in the current state, clear > start_stop > lap
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = start_stop ? RUN : IDLE;
      RUN:   state_d = start_stop ? PAUSE : lap ? LAP : RUN;
      LAP:   state_d = start_stop ? PAUSE : lap ? RUN : LAP;
      PAUSE: state_d = clear ? IDLE : start_stop ? RUN : PAUSE;
    endcase
    pre_d = (clr || tick) ? '0 : active ? pre_q + PW'(1) : pre_q;
  end
  bcd_digit u_ones (.clk(clk), .rstn(rstn), .clr(clr), .inc(tick), .q(ones), .carry(ones_carry));
  bcd_digit u_tens (.clk(clk), .rstn(rstn), .clr(clr), .inc(ones_carry), .q(tens), .carry(wrap_next));
  // state, prescaler, lap latch and registered status outputs
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      lat_tens_q   <= '0;
      lat_ones_q   <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      lat_tens_q   <= lap_cap ? tens : lat_tens_q;
      lat_ones_q   <= lap_cap ? ones : lat_ones_q;
      running_q    <= state_d == RUN || state_d == LAP;
      lap_active_q <= state_d == LAP;
      wrap_q       <= wrap_next;
    end
  assign disp_tens  = lap_active_q ? lat_tens_q : tens;
  assign disp_ones  = lap_active_q ? lat_ones_q : ones;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Two-digit BCD stopwatch controller: sequences a 00–99 decimal count from three single-cycle command pulses (start/stop, lap, clear), with a programmable prescaler setting the count rate. Owns the run/pause/lap state machine, the prescaler, the two-digit BCD count register and a lap-freeze display latch. Sits between debounced pushbutton pulses and a seven-segment display driver.

## Interface
- `TICK_DIV`, default 1000: clk cycles per count increment; legal range ≥ 1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rstn` input, 1 bit: asynchronous, active-low reset.
- `start_stop` input, 1 bit: one-cycle command pulse; toggles run/pause.
- `lap` input, 1 bit: one-cycle command pulse; freezes or releases the display.
- `clear` input, 1 bit: one-cycle command pulse; zeroes the count, honoured only in PAUSE.
- `disp_tens` output, 4 bits: displayed tens digit, BCD 0–9.
- `disp_ones` output, 4 bits: displayed ones digit, BCD 0–9.
- `running` output, 1 bit: 1 in RUN or LAP.
- `lap_active` output, 1 bit: 1 in LAP (display frozen).
- `wrap` output, 1 bit: one-cycle pulse on the edge where the count goes 99→00.

## Operation
- States: IDLE, RUN, LAP, PAUSE.
  - IDLE means count is 00, prescaler is 0 and the block is stopped.
- Transitions, evaluated at each rising edge:
  - IDLE: `start_stop` → RUN. `lap` and `clear` are ignored.
  - RUN: `start_stop` → PAUSE. Otherwise `lap` → LAP, capturing the current count into the display latch. `clear` is ignored.
  - LAP: `start_stop` → PAUSE, and the display returns to the live count. Otherwise `lap` → RUN, live display. `clear` is ignored.
  - PAUSE: `clear` → IDLE, which zeroes the count and prescaler. Otherwise `start_stop` → RUN. `lap` is ignored.
- Simultaneous pulses: only commands valid in the current state are considered. Priority among them is `clear` > `start_stop` > `lap`.
- Prescaler `pre`, width `$clog2(TICK_DIV)` (minimum 1 bit):
  - In RUN/LAP it increments each cycle. When `pre == TICK_DIV-1`, `tick=1` and `pre` reloads to 0.
  - It holds in PAUSE, so the phase is preserved across pause/resume.
  - With `TICK_DIV=1`, `tick=1` every RUN/LAP cycle.
- Count: `count_en = tick`, qualified by the current state (RUN/LAP) before the edge. A tick in the same cycle as a `start_stop` that leads to PAUSE is still applied.
- BCD increment: ones 9→0 with carry into tens. Tens 9→0 only on carry from ones 9, which is the 99→00 wrap and raises `wrap`. Digits never hold values outside 0–9.
- Display: LAP shows the latched value. All other states show the live count. Counting continues underneath the lap freeze.

## Timing
- Reset (`rstn=0`, asynchronous): state IDLE, `pre=0`, count 00, latch 00.
  - Output reset values: `disp_tens=0`, `disp_ones=0`, `running=0`, `lap_active=0`, `wrap=0`.
- All outputs are registered or decoded from registers; no input-to-output combinational path.
- `start_stop` at edge E0 in IDLE: `running=1` after E0. First increment is visible after edge E0+TICK_DIV.
- `lap` at edge E: display frozen at the count held before E. A tick coinciding with E advances only the live count.
- `wrap` is high for exactly the cycle following the wrapping edge, aligned with the digits reading 00.
- Reset mid-operation aborts immediately. The first command after reset release is honoured.

## Structure
- Package `stopwatch_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} sw_state_t`
  - `typedef logic [3:0] bcd_t`
  - `localparam bcd_t BCD_MAX = 4'd9`
- Sub-module `bcd_digit` (`clk`, `rstn`, `clr`, `inc`, output `bcd_t q`, output `carry`), instantiated twice.
  - `carry = inc & (q == 9)`.
  - Ones `carry` drives tens `inc`. Tens `carry` is `wrap_next`.
- Top level contains the FSM, prescaler, lap latch and `wrap` register.

## Test plan
All scenarios use `TICK_DIV=4` unless noted.
- Reset: assert `rstn=0` mid-cycle → all outputs 0 immediately, state IDLE. Release, then send `start_stop` → first increment after 4 cycles.
- Run: `start_stop` pulse, wait 40 cycles → display reads 1,0; `running=1`; no `wrap`.
- Wrap: run 400 cycles from 00 → exactly one `wrap` pulse, coincident with the display reading 0,0 after 9,9. Tens and ones always ≤ 9.
- Lap: `lap` at count 05, wait 12 cycles → display holds 05 with `lap_active=1`. Second `lap` → display shows 08 and `lap_active=0`.
- Pause/clear:
  - Pause with `pre=2`, idle 50 cycles → count unchanged.
  - Resume → next increment after 2 cycles.
  - `clear` in RUN → ignored. `clear` in PAUSE → 00, IDLE.
- Simultaneous: `clear` + `start_stop` in PAUSE → IDLE, 00. `start_stop` + `lap` in RUN → PAUSE. Repeat with `TICK_DIV=1` → increment every cycle.
